instr_issue_unit: RTL and testbench

Producer side of the pipeline's instruction input. Accepts 32-bit instruction words from a loader over a valid/ready write port and buffers them in a FIFO. Presents exactly one word per clock on the pipeline's instruction input. Because the pipeline has no forwarding, the block inserts NOP bubbles (32'h0) whenever the head instruction reads a register written by a recently issued instruction.

---
 rtl/instr_issue_unit_if.sv | 31 +++
 rtl/instr_issue_unit.sv | 159 +++++++++++++++
 tb/tb_instr_issue_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_issue_unit_if.sv
// Instruction issue bus: loader write port, run/flush controls and the
// issued-instruction outputs with their status counters.
interface instr_issue_unit_if #(
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          wr_valid;
   logic [31:0]   wr_instr;
   logic          wr_ready;
   logic          run;
   logic          flush;
   logic [31:0]   instr_out;
   logic          issue_valid;
   logic          stall;
   logic [CW-1:0] fifo_count;
   logic [15:0]   issued_count;
   logic [15:0]   bubble_count;

   modport master (
      output wr_valid, wr_instr, run, flush,
      input  wr_ready, instr_out, issue_valid, stall,
             fifo_count, issued_count, bubble_count
   );

   modport slave (
      input  wr_valid, wr_instr, run, flush,
      output wr_ready, instr_out, issue_valid, stall,
             fifo_count, issued_count, bubble_count
   );
endinterface

// File: rtl/instr_issue_unit.sv
// Buffers instruction words in a FIFO and issues one slot per clock, inserting
// NOP bubbles while the head reads a register written within HAZARD_DIST slots.
module instr_issue_unit #(
   parameter int DEPTH       = 16,
   parameter int HAZARD_DIST = 3
) (
   input  logic                clk,
   input  logic                reset,
   instr_issue_unit_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t           r_state, w_state_next;
   logic [31:0]      r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [HAZARD_DIST-1:0] r_sb_vld;
   logic [4:0]       r_sb_reg [HAZARD_DIST];
   logic [31:0]      r_instr_out;
   logic             r_issue_valid, r_stall;
   logic [15:0]      r_issued, r_bubbles;

   logic [31:0]      w_head;
   logic             w_empty, w_wr_ready, w_push;
   logic             w_is_r, w_is_i, w_reads_rs, w_reads_rt, w_writes;
   logic [HAZARD_DIST-1:0] w_hit;
   logic             w_hazard, w_slot, w_pop, w_bubble;

   assign w_head     = r_mem[r_rd_ptr];
   assign w_empty    = (r_count == '0);
   assign w_wr_ready = (r_count < CW'(DEPTH));
   assign w_push     = bus.wr_valid && w_wr_ready && !bus.flush;

   // Word 0 has opcode 000 so it decodes as neither class: no reads, no write.
   assign w_is_r     = (w_head[31:29] == 3'b010);
   assign w_is_i     = (w_head[31:29] == 3'b011);
   assign w_reads_rs = w_is_r || w_is_i;
   assign w_reads_rt = w_is_r;
   assign w_writes   = w_is_r || w_is_i;

   generate
      for (genvar gi = 0; gi < HAZARD_DIST; gi++) begin : g_hit
         assign w_hit[gi] = r_sb_vld[gi] &&
            ((w_reads_rs && (r_sb_reg[gi] == w_head[20:16])) ||
             (w_reads_rt && (r_sb_reg[gi] == w_head[15:11])));
      end
   endgenerate

   assign w_hazard = !w_empty && (|w_hit);

   always_comb begin
      w_state_next = r_state;
      w_slot       = 1'b0;
      w_pop        = 1'b0;
      w_bubble     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.run) w_state_next = S_RUN;
         end
         S_RUN: begin
            if (!bus.run) begin
               w_state_next = S_IDLE;
            end else begin
               w_slot = 1'b1;
               if (!w_empty) begin
                  if (w_hazard) w_bubble = 1'b1;
                  else          w_pop    = 1'b1;
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= bus.wr_instr;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (bus.flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry 0 holds the destination of the most recent slot; older ones age outward.
   generate
      for (genvar gi = 0; gi < HAZARD_DIST; gi++) begin : g_sb
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_sb_vld[gi] <= 1'b0;
               r_sb_reg[gi] <= '0;
            end else if (bus.flush) begin
               r_sb_vld[gi] <= 1'b0;
               r_sb_reg[gi] <= '0;
            end else if (w_slot) begin
               if (gi == 0) begin
                  r_sb_vld[gi] <= w_pop && w_writes;
                  r_sb_reg[gi] <= w_head[25:21];
               end else begin
                  r_sb_vld[gi] <= r_sb_vld[(gi == 0) ? 0 : gi - 1];
                  r_sb_reg[gi] <= r_sb_reg[(gi == 0) ? 0 : gi - 1];
               end
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_instr_out   <= '0;
         r_issue_valid <= 1'b0;
         r_stall       <= 1'b0;
         r_issued      <= '0;
         r_bubbles     <= '0;
      end else if (bus.flush) begin
         r_instr_out   <= '0;
         r_issue_valid <= 1'b0;
         r_stall       <= 1'b0;
         r_issued      <= '0;
         r_bubbles     <= '0;
      end else begin
         r_instr_out   <= w_pop ? w_head : 32'h0;
         r_issue_valid <= w_pop;
         r_stall       <= w_bubble;
         if (w_pop && (r_issued != 16'hFFFF))     r_issued  <= r_issued + 16'd1;
         if (w_bubble && (r_bubbles != 16'hFFFF)) r_bubbles <= r_bubbles + 16'd1;
      end
   end

   assign bus.wr_ready     = w_wr_ready;
   assign bus.instr_out    = r_instr_out;
   assign bus.issue_valid  = r_issue_valid;
   assign bus.stall        = r_stall;
   assign bus.fifo_count   = r_count;
   assign bus.issued_count = r_issued;
   assign bus.bubble_count = r_bubbles;
endmodule

// File: tb/tb_instr_issue_unit.sv
// Directed bench for instr_issue_unit: expected issue slots are queued by the
// stimulus and matched by an independent monitor; status values checked inline.
module tb_instr_issue_unit;
   logic clk;
   logic reset;

   instr_issue_unit_if #(.DEPTH(16)) bus ();

   instr_issue_unit #(.DEPTH(16), .HAZARD_DIST(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [31:0] instr;
      logic        bubble;
   } slot_t;

   slot_t exp_q[$];
   int    checks   = 0;
   int    failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] w);
      bus.wr_valid = 1'b1;
      bus.wr_instr = w;
      tick(1);
      bus.wr_valid = 1'b0;
   endtask

   task automatic expect_slot(input logic [31:0] w, input logic bub);
      slot_t s;
      s.instr  = w;
      s.bubble = bub;
      exp_q.push_back(s);
   endtask

   // Monitor: every non-empty slot (real issue or bubble) must match the queue head.
   initial begin
      slot_t s;
      forever begin
         @(negedge clk);
         if (reset === 1'b1 && (bus.issue_valid === 1'b1 || bus.stall === 1'b1)) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL slot_unexpected: got instr=%h valid=%b stall=%b, expected no slot",
                        bus.instr_out, bus.issue_valid, bus.stall);
            end else begin
               s = exp_q.pop_front();
               if (bus.instr_out !== s.instr || bus.issue_valid !== !s.bubble ||
                   bus.stall !== s.bubble) begin
                  failures++;
                  $display("FAIL slot: got instr=%h valid=%b stall=%b, expected instr=%h valid=%b stall=%b",
                           bus.instr_out, bus.issue_valid, bus.stall, s.instr, !s.bubble, s.bubble);
               end else begin
                  $display("slot instr=%h valid=%b stall=%b", bus.instr_out, bus.issue_valid, bus.stall);
               end
            end
         end
      end
   end

   initial begin
      reset        = 1'b0;
      bus.wr_valid = 1'b0;
      bus.wr_instr = 32'h0;
      bus.run      = 1'b0;
      bus.flush    = 1'b0;
      tick(3);
      reset = 1'b1;
      tick(1);

      // Reset state
      chk("rst_instr_out", bus.instr_out, 32'h0);
      chk("rst_valid", 32'(bus.issue_valid), 32'h0);
      chk("rst_stall", 32'(bus.stall), 32'h0);
      chk("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
      chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
      chk("rst_issued", 32'(bus.issued_count), 32'd0);
      chk("rst_bubbles", 32'(bus.bubble_count), 32'd0);

      // Independent stream
      bus.run = 1'b1;
      expect_slot(32'h7400_0005, 1'b0);
      expect_slot(32'h7421_000A, 1'b0);
      wr(32'h7400_0005);
      wr(32'h7421_000A);
      tick(6);
      chk("indep_issued", 32'(bus.issued_count), 32'd2);
      chk("indep_bubbles", 32'(bus.bubble_count), 32'd0);
      chk("indep_drain", 32'(exp_q.size()), 32'd0);

      // RAW hazard: reader of r0 right after its producer -> 3 bubbles
      expect_slot(32'h7400_0005, 1'b0);
      expect_slot(32'h0, 1'b1);
      expect_slot(32'h0, 1'b1);
      expect_slot(32'h0, 1'b1);
      expect_slot(32'h5501_0000, 1'b0);
      wr(32'h7400_0005);
      wr(32'h5501_0000);
      tick(8);
      chk("raw_bubbles", 32'(bus.bubble_count), 32'd3);
      chk("raw_issued", 32'(bus.issued_count), 32'd4);
      chk("raw_drain", 32'(exp_q.size()), 32'd0);

      // Partial distance: two independents in between -> 1 bubble
      bus.run = 1'b0;
      tick(1);
      wr(32'h7400_0005);
      wr(32'h7442_0001);
      wr(32'h7463_0002);
      wr(32'h7480_0007);
      expect_slot(32'h7400_0005, 1'b0);
      expect_slot(32'h7442_0001, 1'b0);
      expect_slot(32'h7463_0002, 1'b0);
      expect_slot(32'h0, 1'b1);
      expect_slot(32'h7480_0007, 1'b0);
      bus.run = 1'b1;
      tick(10);
      chk("part_bubbles", 32'(bus.bubble_count), 32'd4);
      chk("part_issued", 32'(bus.issued_count), 32'd8);
      chk("part_drain", 32'(exp_q.size()), 32'd0);

      // Full and wrap
      bus.run = 1'b0;
      tick(1);
      for (int i = 0; i < 16; i++) wr(32'hA000_0000 + 32'(i));
      chk("full_count", 32'(bus.fifo_count), 32'd16);
      chk("full_wr_ready", 32'(bus.wr_ready), 32'd0);
      wr(32'hDEAD_BEEF);
      chk("full_17th_dropped", 32'(bus.fifo_count), 32'd16);
      for (int i = 0; i < 16; i++) expect_slot(32'hA000_0000 + 32'(i), 1'b0);
      bus.run = 1'b1;
      tick(20);
      chk("full_drain", 32'(exp_q.size()), 32'd0);
      for (int i = 0; i < 8; i++) begin
         expect_slot(32'hB000_0000 + 32'(i), 1'b0);
         wr(32'hB000_0000 + 32'(i));
      end
      tick(6);
      chk("wrap_issued", 32'(bus.issued_count), 32'd32);
      chk("wrap_drain", 32'(exp_q.size()), 32'd0);

      // Flush with a simultaneous write
      bus.run = 1'b0;
      tick(1);
      for (int i = 0; i < 5; i++) wr(32'hC000_0000 + 32'(i));
      chk("pre_flush_count", 32'(bus.fifo_count), 32'd5);
      bus.flush    = 1'b1;
      bus.wr_valid = 1'b1;
      bus.wr_instr = 32'h7400_1111;
      tick(1);
      bus.flush    = 1'b0;
      bus.wr_valid = 1'b0;
      chk("flush_count", 32'(bus.fifo_count), 32'd0);
      chk("flush_issued", 32'(bus.issued_count), 32'd0);
      chk("flush_bubbles", 32'(bus.bubble_count), 32'd0);
      chk("flush_instr_out", bus.instr_out, 32'h0);
      chk("flush_wr_ready", 32'(bus.wr_ready), 32'd1);
      bus.run = 1'b1;
      tick(4);
      chk("flush_write_dropped", 32'(bus.fifo_count), 32'd0);
      chk("flush_nothing_issued", 32'(bus.issued_count), 32'd0);
      bus.run = 1'b0;
      tick(2);
      chk("idle_instr_out", bus.instr_out, 32'h0);
      chk("idle_valid", 32'(bus.issue_valid), 32'd0);

      // Asynchronous reset mid-stream
      for (int i = 1; i <= 6; i++) begin
         expect_slot(32'h9000_0000 + 32'(i), 1'b0);
         wr(32'h9000_0000 + 32'(i));
      end
      bus.run = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("pre_reset_instr_out", bus.instr_out, 32'h9000_0001);
      #2;
      reset = 1'b0;
      #1;
      chk("areset_instr_out", bus.instr_out, 32'h0);
      chk("areset_count", 32'(bus.fifo_count), 32'd0);
      chk("areset_wr_ready", 32'(bus.wr_ready), 32'd1);
      chk("areset_valid", 32'(bus.issue_valid), 32'd0);
      chk("areset_issued", 32'(bus.issued_count), 32'd0);
      exp_q.delete();
      bus.run = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(3);
      chk("post_reset_count", 32'(bus.fifo_count), 32'd0);
      chk("final_drain", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
